// File: rtl/jedro_1_data_ram.sv
// Single-port data memory that answers the core's data-memory interface.
// After every reset the array is zero-filled, one word per cycle, before
// requests are granted. Once ready it accepts one request per cycle and
// responds exactly one cycle later. Writes are byte-enabled and respond
// with the merged word. Misaligned or out-of-range requests respond with
// err_o and do not touch the array.
//
// Handshake: a request is accepted in any cycle where req_i && gnt_o at
// the rising edge. Exactly one rvalid_o pulse follows each accepted request,
// on the next cycle and in request order. err_o and rdata_o are meaningful
// only while rvalid_o is high; rdata_o holds its value between responses.
module jedro_1_data_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

  logic [IDX_W-1:0]       req_idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   req_err;
  logic                   accepted;
  logic                   is_write;
  logic [DATA_WIDTH-1:0]  merged;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  // Decode the request address and form the byte-merged write word.
  always_comb begin
    req_idx      = addr_i[IDX_W+1:2];
    misaligned   = (addr_i[1:0] != 2'b00);
    out_of_range = (addr_i[ADDR_WIDTH-1:IDX_W+2] != '0);
    req_err      = misaligned | out_of_range;
    gnt_o        = (state_q == ST_READY) & rstn_i;
    accepted     = req_i & gnt_o;
    is_write     = (we_i != '0);
    merged       = mem[req_idx];
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) merged[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  // Next-state logic for the clear/ready FSM and the response registers.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_wdata = merged;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = rstn_i;
        mem_idx   = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
      end
      ST_READY: begin
        if (accepted) begin
          rvalid_d = 1'b1;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (is_write) begin
            mem_we  = 1'b1;
            rdata_d = merged;
          end else begin
            rdata_d = mem[req_idx];
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage array: one write port shared by the clear sweep and core writes.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Directed bench for jedro_1_data_ram: reset/clear timing, reads, full and
// byte-enabled writes, error responses, back-to-back traffic, mid-run reset.
module tb_jedro_1_data_ram;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        gnt;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  jedro_1_data_ram dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rstn  = 1'b0;
    req   = 1'b0;
    we    = '0;
    addr  = '0;
    wdata = '0;
  end

  // Driver: present one request from the negedge, let it be accepted at the
  // next posedge, then sample the response #1 after that edge.
  task automatic drive_req(input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = '0;
  endtask

  // Counts posedges until gnt rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (gnt !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rvalid=%b err=%b rdata=%h gnt=%b, want 0/0/0/0",
               rvalid, err, rdata, gnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_length: gnt rose after %0d cycles, want 256", n);
    end
  endtask

  task automatic test_read_zero;
    @(negedge clk);
    drive_req(4'b0000, 32'h10, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_zero: rvalid=%b err=%b rdata=%h, want 1/0/00000000",
               rvalid, err, rdata);
    end
  endtask

  task automatic test_full_write;
    @(negedge clk);
    drive_req(4'b1111, 32'h40, 32'hDEADBEEF);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_resp: rvalid=%b err=%b rdata=%h, want 1/0/deadbeef",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h40, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_readback: rvalid=%b err=%b rdata=%h, want 1/0/deadbeef",
               rvalid, err, rdata);
    end
  endtask

  task automatic test_byte_enable;
    @(negedge clk);
    drive_req(4'b0010, 32'h40, 32'h0000AA00);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL be_write_resp: rvalid=%b err=%b rdata=%h, want 1/0/deadaaef",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h40, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL be_readback: rvalid=%b rdata=%h, want 1/deadaaef", rvalid, rdata);
    end
    // Idle cycle: no pulse, data held.
    @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL idle_hold: rvalid=%b err=%b rdata=%h, want 0/0/deadaaef",
               rvalid, err, rdata);
    end
  endtask

  task automatic test_errors;
    @(negedge clk);
    drive_req(4'b0000, 32'h41, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL misaligned: rvalid=%b err=%b rdata=%h, want 1/1/00000000",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b1111, 32'h400, 32'h12345678);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL out_of_range: rvalid=%b err=%b rdata=%h, want 1/1/00000000",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h000, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL no_alias: rvalid=%b err=%b rdata=%h, want 1/0/00000000",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h40, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL err_no_side_effect: rvalid=%b err=%b rdata=%h, want 1/0/deadaaef",
               rvalid, err, rdata);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive_req(4'b1111, 32'h8, 32'h000000A5);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h000000A5) begin
      errors++;
      $display("FAIL b2b_write: rvalid=%b err=%b rdata=%h, want 1/0/000000a5",
               rvalid, err, rdata);
    end
    // Read issued in the very next cycle, no gap.
    drive_req(4'b0000, 32'h8, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h000000A5) begin
      errors++;
      $display("FAIL b2b_read: rvalid=%b err=%b rdata=%h, want 1/0/000000a5",
               rvalid, err, rdata);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    int pulses;
    @(negedge clk);
    drive_req(4'b1111, 32'h40, 32'hCAFEF00D);
    checks++;
    if (rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pre_reset_write: rdata=%h, want cafef00d", rdata);
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // Requests during clear must be ignored.
    pulses = 0;
    req   = 1'b1;
    we    = 4'b1111;
    addr  = 32'h80;
    wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1 || gnt === 1'b1) pulses++;
    end
    req = 1'b0;
    we  = '0;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL clear_ignores_req: %0d cycles with rvalid/gnt high, want 0", pulses);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_clear_length: gnt rose after %0d cycles, want 256", n);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h40, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL cleared_0x40: rvalid=%b err=%b rdata=%h, want 1/0/00000000",
               rvalid, err, rdata);
    end
    @(negedge clk);
    drive_req(4'b0000, 32'h80, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL cleared_0x80: rvalid=%b rdata=%h, want 1/00000000", rvalid, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_full_write();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_data_ram.md
Name: jedro_1_data_ram

Overview:
Single-port data memory that acts as the responder on the core's data-memory read/write interface. It sits on the core's data_mem_if and lets load/store bench programs run against real memory. After every reset it zero-fills its array, then accepts one request per cycle with one-cycle response latency. Each write uses byte enables. Misaligned and out-of-range accesses get an error response.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8).
ADDR_WIDTH, 32, byte address width.
DEPTH_WORDS, 256, number of DATA_WIDTH words (power of two).
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the clear, go directly to READY.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rstn_i  input  1  synchronous active-low reset.
req_i  input  1  request valid from core.
gnt_o  output  1  request accepted this cycle when req_i & gnt_o.
we_i  input  DATA_WIDTH/8  byte write enables; all-zero = read.
addr_i  input  ADDR_WIDTH  byte address.
wdata_i  input  DATA_WIDTH  write data.
rvalid_o  output  1  one-cycle response pulse.
rdata_o  output  DATA_WIDTH  response data.
err_o  output  1  error flag, qualified by rvalid_o.

Behaviour:
- Reset (rstn_i low at posedge):
  - state <= CLEAR if CLEAR_ON_RESET, else READY.
  - clr_cnt <= 0.
  - rvalid_o, err_o, rdata_o <= 0.
  - Any pending response is dropped.
- gnt_o = (state == READY), combinational from state. gnt_o is 0 while in reset.
- CLEAR state:
  - Each cycle, mem[clr_cnt] <= 0 and clr_cnt increments.
  - After the write at clr_cnt == DEPTH_WORDS-1, state <= READY.
  - gnt_o first rises exactly DEPTH_WORDS cycles after the first posedge with rstn_i high.
  - req_i is ignored in CLEAR: no write, no rvalid_o.
- READY state: stays READY until reset.
- Request decode:
  - Word index = addr_i[log2(DEPTH_WORDS)+1:2].
  - Misaligned: addr_i[1:0] != 0.
  - Out-of-range: (addr_i >> 2) >= DEPTH_WORDS, i.e. any address bit above the index is set.
- Accepted request with error:
  - No memory update.
  - Next cycle: rvalid_o=1, err_o=1, rdata_o=0.
- Accepted write (we_i != 0, no error):
  - Only bytes b with we_i[b]=1 are updated; other bytes are kept.
  - Next cycle: rvalid_o=1, err_o=0, rdata_o = merged new word (write-first).
- Accepted read (we_i == 0, no error):
  - Next cycle: rvalid_o=1, err_o=0, rdata_o = mem[index].
- Back-to-back:
  - One request per cycle, full throughput.
  - A read in the cycle after a write to the same word returns the written data. No stale read is allowed.
- Idle cycle (no accepted request):
  - Next cycle: rvalid_o=0, err_o=0.
  - rdata_o holds its last value.
- Response ordering: in request order, exactly one rvalid_o per accepted request.
- Reset mid-operation:
  - During CLEAR: the clear restarts from word 0.
  - During READY: the in-flight response is dropped and a full clear runs, so all data written earlier reads back 0.

Test Plan:
- Hold rstn_i low 3 cycles, then release:
  - gnt_o=0 for exactly 256 cycles, then 1.
  - Read 0x10 -> next cycle rvalid_o=1, rdata_o=0x00000000, err_o=0.
- Write 0xDEADBEEF to 0x40 with we_i=4'b1111, then read 0x40 -> rdata_o=0xDEADBEEF, err_o=0.
- After the previous step, write wdata_i=0x0000AA00 to 0x40 with we_i=4'b0010, then read 0x40 -> rdata_o=0xDEADAAEF.
- Error accesses:
  - Read 0x41 -> rvalid_o=1, err_o=1, rdata_o=0.
  - Write 0x12345678 to 0x400 with we_i=4'b1111 -> err_o=1.
  - Then read 0x000 -> rdata_o=0, err_o=0.
- Consecutive-cycle write 0x0000_00A5 to 0x8, then read 0x8 -> two rvalid_o pulses on consecutive cycles; the second has rdata_o=0x000000A5.
- Write 0xCAFEF00D to 0x40, then assert rstn_i for 1 cycle and release. Reassert it 100 cycles later for 1 cycle and release again:
  - gnt_o stays 0 until 256 cycles after the second release.
  - Read 0x40 -> rdata_o=0.
